mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared arbiter FSM states, owner tags, access sizes, rw codes.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam logic [1:0] ACCESS_BYTE = 2'd0;
    localparam logic [1:0] ACCESS_HALF = 2'd1;
    localparam logic [1:0] ACCESS_WORD = 2'd2;

    localparam logic MEM_RW_READ  = 1'b1;
    localparam logic MEM_RW_WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one memory port between instruction fetch and data access.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic [1:0]  i_access_size,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_access_size,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic [1:0]  m_access_size,
    output logic        m_rw,
    output logic        m_enable,
    input  logic        m_busy,
    input  logic [31:0] m_data_out,
    output logic        stall_fetch,
    output logic        stall_mem
);

    localparam int c_STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);

    arb_state_t             r_state;
    arb_owner_t             r_owner;
    logic [c_STREAK_W-1:0]  r_d_streak;
    logic                   w_grant_fetch;

    // Data has priority unless it has already starved a waiting fetch long enough.
    assign w_grant_fetch = i_req & (~d_req | (r_d_streak == c_STREAK_MAX));

    assign stall_fetch = i_req & ~i_ack;
    assign stall_mem   = d_req & ~d_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_FETCH;
            r_d_streak    <= '0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            m_enable      <= 1'b0;
            m_rw          <= MEM_RW_READ;
            m_address     <= '0;
            m_data_in     <= '0;
            m_access_size <= ACCESS_BYTE;
        end else begin
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            m_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        r_state  <= ST_ISSUE;
                        m_enable <= 1'b1;
                        if (w_grant_fetch) begin
                            r_owner       <= OWN_FETCH;
                            m_address     <= i_address;
                            m_access_size <= i_access_size;
                            m_rw          <= MEM_RW_READ;
                            r_d_streak    <= '0;
                        end else begin
                            r_owner       <= OWN_DATA;
                            m_address     <= d_address;
                            m_data_in     <= d_wdata;
                            m_access_size <= d_access_size;
                            m_rw          <= d_rw;
                            if (i_req && (r_d_streak != c_STREAK_MAX)) begin
                                r_d_streak <= r_d_streak + 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!m_busy) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_FETCH) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_data_out;
                        end else begin
                            d_ack <= 1'b1;
                            // Stores complete without disturbing the last load result.
                            if (m_rw == MEM_RW_READ) begin
                                d_rdata <= m_data_out;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mips_pkg::*;

    localparam int MAX_D_STREAK = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_address = '0;
    logic [1:0]  i_access_size = ACCESS_WORD;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_rw = MEM_RW_READ;
    logic [31:0] d_address = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_access_size = ACCESS_WORD;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] m_address;
    logic [31:0] m_data_in;
    logic [1:0]  m_access_size;
    logic        m_rw;
    logic        m_enable;
    logic        m_busy = 1'b0;
    logic [31:0] m_data_out = '0;
    logic        stall_fetch;
    logic        stall_mem;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_access_size(i_access_size),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_address(d_address), .d_wdata(d_wdata),
        .d_access_size(d_access_size), .d_ack(d_ack), .d_rdata(d_rdata),
        .m_address(m_address), .m_data_in(m_data_in), .m_access_size(m_access_size),
        .m_rw(m_rw), .m_enable(m_enable), .m_busy(m_busy), .m_data_out(m_data_out),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one access in flight; it is answered on the first
    // edge at least two edges after its grant that sees the memory idle, and
    // the edge after an answer is spent returning to arbitration.
    bit          txn_open, answered, own_fetch, own_read, din_valid;
    int          age, streak;
    logic        exp_iack, exp_dack, exp_en, exp_rw;
    logic [31:0] exp_addr, exp_din, exp_irdata, exp_drdata;
    logic [1:0]  exp_size;

    always @(posedge clock) begin
        if (reset) begin
            txn_open = 0; answered = 0; own_fetch = 1; own_read = 1; din_valid = 1;
            age = 0; streak = 0;
            exp_iack = 0; exp_dack = 0; exp_en = 0; exp_rw = 1'b1;
            exp_addr = '0; exp_din = '0; exp_size = '0; exp_irdata = '0; exp_drdata = '0;
        end else begin
            exp_iack = 0; exp_dack = 0; exp_en = 0;
            if (answered) begin
                answered = 0;
                txn_open = 0;
            end else if (!txn_open) begin
                if (i_req || d_req) begin
                    own_fetch = i_req && (!d_req || streak == MAX_D_STREAK);
                    txn_open = 1; age = 0; exp_en = 1;
                    if (own_fetch) begin
                        exp_addr = i_address; exp_size = i_access_size; exp_rw = 1'b1;
                        own_read = 1; din_valid = 0; streak = 0;
                    end else begin
                        exp_addr = d_address; exp_size = d_access_size; exp_rw = d_rw;
                        own_read = d_rw; exp_din = d_wdata; din_valid = 1;
                        if (i_req && streak < MAX_D_STREAK) streak++;
                    end
                end
            end else begin
                age++;
                if (age >= 2 && !m_busy) begin
                    answered = 1;
                    if (own_fetch) begin
                        exp_iack = 1; exp_irdata = m_data_out;
                    end else begin
                        exp_dack = 1;
                        if (own_read) exp_drdata = m_data_out;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("m_i_ack",       32'(i_ack), 32'(exp_iack));
            check("m_d_ack",       32'(d_ack), 32'(exp_dack));
            check("m_enable",      32'(m_enable), 32'(exp_en));
            check("m_address",     m_address, exp_addr);
            check("m_access_size", 32'(m_access_size), 32'(exp_size));
            check("m_rw",          32'(m_rw), 32'(exp_rw));
            check("m_i_rdata",     i_rdata, exp_irdata);
            check("m_d_rdata",     d_rdata, exp_drdata);
            check("m_stall_fetch", 32'(stall_fetch), 32'(i_req & ~exp_iack));
            check("m_stall_mem",   32'(stall_mem), 32'(d_req & ~exp_dack));
            check("ack_overlap",   32'(i_ack & d_ack), 32'd0);
            if (din_valid) check("m_data_in", m_data_in, exp_din);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [5:0] seq;
    int         nseq;

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("rst_m_rw", 32'(m_rw), 32'd1);
        check("rst_m_enable", 32'(m_enable), 32'd0);
        check("rst_m_address", m_address, 32'h0);
        check("rst_m_data_in", m_data_in, 32'h0);
        check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'h0);

        // Fetch only
        i_req = 1; i_address = 32'h8002_0000; m_data_out = 32'h2402_0005;
        tick();
        check("f_enable_e1", 32'(m_enable), 32'd1);
        tick();
        check("f_enable_e2", 32'(m_enable), 32'd0);
        check("f_noack_e2", 32'(i_ack), 32'd0);
        tick();
        check("f_ack_e3", 32'(i_ack), 32'd1);
        check("f_rdata", i_rdata, 32'h2402_0005);
        tick();
        check("f_ack_gone", 32'(i_ack), 32'd0);
        i_req = 0;
        tick();

        // Collision: data store wins, then fetch
        i_req = 1; i_address = 32'h8002_0040;
        d_req = 1; d_rw = MEM_RW_WRITE; d_address = 32'h8002_0100; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("c_d_enable", 32'(m_enable), 32'd1);
        check("c_d_rw", 32'(m_rw), 32'd0);
        check("c_d_addr", m_address, 32'h8002_0100);
        check("c_d_wdata", m_data_in, 32'hDEAD_BEEF);
        check("c_stall_f1", 32'(stall_fetch), 32'd1);
        tick(); tick();
        check("c_d_ack", 32'(d_ack), 32'd1);
        check("c_stall_f2", 32'(stall_fetch), 32'd1);
        tick();
        d_req = 0;
        check("c_d_rdata_kept", d_rdata, 32'h0);
        tick();
        check("c_f_enable", 32'(m_enable), 32'd1);
        check("c_f_rw", 32'(m_rw), 32'd1);
        check("c_f_addr", m_address, 32'h8002_0040);
        tick(); tick();
        check("c_i_ack", 32'(i_ack), 32'd1);
        check("c_stall_f3", 32'(stall_fetch), 32'd0);
        tick();
        i_req = 0;
        tick();

        // Busy stretch of five cycles
        i_req = 1; i_address = 32'h8002_0080; m_data_out = 32'h1111_2222;
        tick();
        check("b_enable", 32'(m_enable), 32'd1);
        tick();
        m_busy = 1;
        for (int k = 2; k <= 6; k++) begin
            tick();
            check("b_noack", 32'(i_ack), 32'd0);
            check("b_addr_stable", m_address, 32'h8002_0080);
            if (k == 6) m_busy = 0;
        end
        tick();
        check("b_ack", 32'(i_ack), 32'd1);
        check("b_rdata", i_rdata, 32'h1111_2222);
        tick();
        i_req = 0;
        tick();

        // Starvation limit
        d_req = 1; d_rw = MEM_RW_READ; d_address = 32'h8002_0200; m_data_out = 32'hCAFE_0000;
        i_req = 1; i_address = 32'h8002_0300;
        seq = '0; nseq = 0;
        for (int k = 0; k < 80 && nseq < 6; k++) begin
            tick();
            if (d_ack) begin seq = {seq[4:0], 1'b0}; nseq++; end
            if (i_ack) begin seq = {seq[4:0], 1'b1}; nseq++; i_req = 0; end
        end
        d_req = 0;
        check("s_ack_count", 32'(nseq), 32'd6);
        check("s_order", 32'(seq), 32'h02);
        check("s_d_rdata", d_rdata, 32'hCAFE_0000);
        tick(); tick();

        // Reset while waiting on a busy memory
        i_req = 1; i_address = 32'h8002_0400; m_data_out = 32'h5555_5555;
        tick();
        check("r_enable", 32'(m_enable), 32'd1);
        tick();
        m_busy = 1;
        tick();
        reset = 1;
        #1;
        check("r_async_enable", 32'(m_enable), 32'd0);
        check("r_async_rw", 32'(m_rw), 32'd1);
        check("r_async_addr", m_address, 32'h0);
        tick();
        check("r_no_ack", 32'(i_ack | d_ack), 32'd0);
        reset = 0; m_busy = 0;
        tick();
        check("r_regrant", 32'(m_enable), 32'd1);
        tick(); tick();
        check("r_ack", 32'(i_ack), 32'd1);
        check("r_rdata", i_rdata, 32'h5555_5555);
        tick();
        i_req = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
